// File: rtl/exe_stage.sv
// exe_stage: execute stage of the filter processor pipeline.
// Picks forwarded ALU operands, runs single-cycle ALU ops or an iterative
// Q(DATA_W-FRAC_BITS).FRAC_BITS multiply, and owns the Exe/Mem register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   valid_in             Reg/Exe register holds a real instruction
//   alu_op               0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 MULQ, else PASSA
//   use_imm, imm         operand B = imm instead of forwarded B
//   ra_data, rb_data     register-file operand values
//   robj_in, we_in       destination register and its write enable
//   mem_we_in            store instruction
//   sel_risk_A/B         00/11 register, 01 alu_result_q, 10 wb_data
//   wb_data              Mem/WB result value
//   stall                freeze fetch, decode and Reg/Exe register
//   *_q                  Exe/Mem pipeline register outputs
//   ovf_q                MULQ result saturated
module exe_stage #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int REG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [3:0]        alu_op,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] ra_data,
    input  logic [DATA_W-1:0] rb_data,
    input  logic [REG_W-1:0]  robj_in,
    input  logic              we_in,
    input  logic              mem_we_in,
    input  logic [1:0]        sel_risk_A,
    input  logic [1:0]        sel_risk_B,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [DATA_W-1:0] store_data_q,
    output logic [REG_W-1:0]  robj_q,
    output logic              we_q,
    output logic              mem_we_q,
    output logic              valid_q,
    output logic              ovf_q
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MULQ = 4'd8;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        shamt;
    logic              is_mulq;

    // Multiplier working state, latched at acceptance so later
    // forwarding changes during the stall cannot disturb the operands.
    logic [CNT_W-1:0]  count;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic              m_neg;
    logic [DATA_W-1:0] m_opb;
    logic [REG_W-1:0]  m_robj;
    logic              m_we;
    logic              m_mwe;

    logic [PROD_W-1:0] prod_signed;
    logic [PROD_W-1:0] prod_shift;
    logic [PROD_W-DATA_W:0] prod_hi;
    logic              mul_ovf;
    logic [DATA_W-1:0] mul_res;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        // The most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    // Operand forwarding
    always_comb begin
        case (sel_risk_A)
            2'b01:   fa = alu_result_q;
            2'b10:   fa = wb_data;
            default: fa = ra_data;
        endcase
    end

    always_comb begin
        case (sel_risk_B)
            2'b01:   fb = alu_result_q;
            2'b10:   fb = wb_data;
            default: fb = rb_data;
        endcase
    end

    assign opb     = use_imm ? imm : fb;
    assign shamt   = opb[3:0];
    assign is_mulq = valid_in && (alu_op == OP_MULQ);

    // Single-cycle ALU
    always_comb begin
        alu_res = fa;
        case (alu_op)
            OP_ADD:  alu_res = fa + opb;
            OP_SUB:  alu_res = fa - opb;
            OP_AND:  alu_res = fa & opb;
            OP_OR:   alu_res = fa | opb;
            OP_XOR:  alu_res = fa ^ opb;
            OP_SLL:  alu_res = fa << shamt;
            OP_SRL:  alu_res = fa >> shamt;
            OP_SRA:  alu_res = $signed(fa) >>> shamt;
            default: alu_res = fa;
        endcase
    end

    // Multiply result: restore sign, drop fraction bits (floor), saturate.
    always_comb begin
        prod_signed = m_neg ? (~acc + PROD_W'(1)) : acc;
        prod_shift  = $signed(prod_signed) >>> FRAC_BITS;
        prod_hi     = prod_shift[PROD_W-1:DATA_W-1];
        mul_ovf     = !((&prod_hi) || !(|prod_hi));
        if (mul_ovf) begin
            mul_res = prod_shift[PROD_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            mul_res = prod_shift[DATA_W-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and stall
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mulq) begin
                    stall   = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (count == LAST_ITER) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Multiplier datapath and Exe/Mem register
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            m_neg        <= 1'b0;
            m_opb        <= '0;
            m_robj       <= '0;
            m_we         <= 1'b0;
            m_mwe        <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            robj_q       <= '0;
            we_q         <= 1'b0;
            mem_we_q     <= 1'b0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mulq) begin
                        count    <= '0;
                        acc      <= '0;
                        mcand    <= {{DATA_W{1'b0}}, mag(fa)};
                        mplier   <= mag(opb);
                        m_neg    <= fa[DATA_W-1] ^ opb[DATA_W-1];
                        m_opb    <= opb;
                        m_robj   <= robj_in;
                        m_we     <= we_in;
                        m_mwe    <= mem_we_in;
                        valid_q  <= 1'b0;
                        we_q     <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else if (valid_in) begin
                        alu_result_q <= alu_res;
                        store_data_q <= fb;
                        robj_q       <= robj_in;
                        we_q         <= we_in;
                        mem_we_q     <= mem_we_in;
                        valid_q      <= 1'b1;
                        ovf_q        <= 1'b0;
                    end else begin
                        valid_q  <= 1'b0;
                        we_q     <= 1'b0;
                        mem_we_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // One shift-add step per cycle, LSB of multiplier first.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    count    <= count + CNT_W'(1);
                    valid_q  <= 1'b0;
                    we_q     <= 1'b0;
                    mem_we_q <= 1'b0;
                end
                S_DONE: begin
                    count        <= '0;
                    alu_result_q <= mul_res;
                    store_data_q <= m_opb;
                    robj_q       <= m_robj;
                    we_q         <= m_we;
                    mem_we_q     <= m_mwe;
                    valid_q      <= 1'b1;
                    ovf_q        <= mul_ovf;
                end
                default: begin
                    valid_q  <= 1'b0;
                    we_q     <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed bench for exe_stage with a
// transaction-level reference model of the Exe/Mem register and stall.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [15:0] imm;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic [3:0]  robj_in;
    logic        we_in;
    logic        mem_we_in;
    logic [1:0]  sel_risk_A;
    logic [1:0]  sel_risk_B;
    logic [15:0] wb_data;
    logic        stall;
    logic [15:0] alu_result_q;
    logic [15:0] store_data_q;
    logic [3:0]  robj_q;
    logic        we_q;
    logic        mem_we_q;
    logic        valid_q;
    logic        ovf_q;

    exe_stage #(.DATA_W(16), .FRAC_BITS(8), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op),
        .use_imm(use_imm), .imm(imm), .ra_data(ra_data), .rb_data(rb_data),
        .robj_in(robj_in), .we_in(we_in), .mem_we_in(mem_we_in),
        .sel_risk_A(sel_risk_A), .sel_risk_B(sel_risk_B), .wb_data(wb_data),
        .stall(stall), .alu_result_q(alu_result_q),
        .store_data_q(store_data_q), .robj_q(robj_q), .we_q(we_q),
        .mem_we_q(mem_we_q), .valid_q(valid_q), .ovf_q(ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model of the Exe/Mem register contents
    logic [15:0] m_res, m_sd;
    logic [3:0]  m_robj;
    logic        m_we, m_mwe, m_valid, m_ovf;
    // Pending multiply, computed whole at acceptance
    logic [15:0] p_res, p_sd;
    logic [3:0]  p_robj;
    logic        p_we, p_mwe, p_ovf;
    int          busy_left = 0;
    bit          in_done   = 0;
    bit          exp_stall = 0;
    bit          dut_stall = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        int sh;
        int sa;
        sh = int'(b[3:0]);
        sa = int'($signed(a));
        case (op)
            4'd0:    return 16'((int'(a) + int'(b)) % 65536);
            4'd1:    return 16'((int'(a) - int'(b) + 65536) % 65536);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return 16'((int'(a) * (1 << sh)) % 65536);
            4'd6:    return 16'(int'(a) / (1 << sh));
            4'd7:    return 16'(sa >>> sh);
            default: return a;
        endcase
    endfunction

    task automatic mulq_model(input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] r, output logic o);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 8;
        o = 1'b0;
        if (p > 32767) begin
            p = 32767;
            o = 1'b1;
        end else if (p < -32768) begin
            p = -32768;
            o = 1'b1;
        end
        r = 16'(p);
    endtask

    // One clock cycle: inputs already driven after a falling edge.
    task automatic tick();
        logic [15:0] fa, fb, ob;
        logic [15:0] n_res, n_sd;
        logic [3:0]  n_robj;
        logic        n_we, n_mwe, n_valid, n_ovf;
        bit          full;
        #1;
        fa = (sel_risk_A == 2'b01) ? m_res :
             (sel_risk_A == 2'b10) ? wb_data : ra_data;
        fb = (sel_risk_B == 2'b01) ? m_res :
             (sel_risk_B == 2'b10) ? wb_data : rb_data;
        ob = use_imm ? imm : fb;
        n_res = m_res; n_sd = m_sd; n_robj = m_robj; n_ovf = m_ovf;
        n_we = 1'b0; n_mwe = 1'b0; n_valid = 1'b0;
        full = 0;
        if (rst) begin
            n_res = '0; n_sd = '0; n_robj = '0; n_ovf = 1'b0;
            busy_left = 0; in_done = 0; exp_stall = 0;
            full = 1;
        end else if (busy_left > 0) begin
            exp_stall = 1;
            busy_left--;
            if (busy_left == 0) in_done = 1;
        end else if (in_done) begin
            exp_stall = 0;
            in_done = 0;
            n_res = p_res; n_sd = p_sd; n_robj = p_robj;
            n_we = p_we; n_mwe = p_mwe; n_valid = 1'b1; n_ovf = p_ovf;
            full = 1;
        end else if (valid_in && alu_op == 4'd8) begin
            exp_stall = 1;
            mulq_model(fa, ob, p_res, p_ovf);
            p_sd = ob; p_robj = robj_in; p_we = we_in; p_mwe = mem_we_in;
            busy_left = 16;
        end else if (valid_in) begin
            exp_stall = 0;
            n_res = alu_model(alu_op, fa, ob);
            n_sd = fb; n_robj = robj_in; n_we = we_in; n_mwe = mem_we_in;
            n_valid = 1'b1; n_ovf = 1'b0;
            full = 1;
        end else begin
            exp_stall = 0;
        end
        if (!rst) begin
            dut_stall = stall;
            chk("stall", 32'(stall), 32'(exp_stall));
        end
        @(posedge clk);
        #1;
        m_res = n_res; m_sd = n_sd; m_robj = n_robj; m_we = n_we;
        m_mwe = n_mwe; m_valid = n_valid; m_ovf = n_ovf;
        chk("valid_q", 32'(valid_q), 32'(m_valid));
        chk("we_q", 32'(we_q), 32'(m_we));
        chk("mem_we_q", 32'(mem_we_q), 32'(m_mwe));
        if (full) begin
            chk("alu_result_q", 32'(alu_result_q), 32'(m_res));
            chk("store_data_q", 32'(store_data_q), 32'(m_sd));
            chk("robj_q", 32'(robj_q), 32'(m_robj));
            chk("ovf_q", 32'(ovf_q), 32'(m_ovf));
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic [3:0] op,
                          input logic ui, input logic [15:0] im,
                          input logic [15:0] ra, input logic [15:0] rb,
                          input logic [3:0] rd, input logic sa1,
                          input logic [1:0] sa, input logic [15:0] wb);
        valid_in = v; alu_op = op; use_imm = ui; imm = im;
        ra_data = ra; rb_data = rb; robj_in = rd; we_in = 1'b1;
        mem_we_in = sa1; sel_risk_A = sa; sel_risk_B = 2'b00;
        wb_data = wb;
    endtask

    task automatic scramble();
        ra_data = 16'($urandom); rb_data = 16'($urandom);
        wb_data = 16'($urandom); imm = 16'($urandom);
        sel_risk_A = 2'($urandom); sel_risk_B = 2'($urandom);
    endtask

    // Run a MULQ already driven on the inputs until its result lands.
    task automatic run_mulq(input string name, input logic [15:0] er,
                            input logic eo);
        int n;
        int guard;
        n = 0;
        guard = 0;
        tick();
        if (dut_stall) n++;
        while (dut_stall && guard < 40) begin
            scramble();
            tick();
            if (dut_stall) n++;
            guard++;
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'd17);
        chk({name, "_res"}, 32'(alu_result_q), 32'(er));
        chk({name, "_ovf"}, 32'(ovf_q), 32'(eo));
        chk({name, "_valid"}, 32'(valid_q), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        m_res = '0; m_sd = '0; m_robj = '0;
        m_we = 0; m_mwe = 0; m_valid = 0; m_ovf = 0;
        rst = 1'b1;
        set_op(0, 4'd0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 16'h0);
        @(negedge clk);
        tick();
        tick();
        chk("reset_res", 32'(alu_result_q), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Simple ADD
        set_op(1, 4'd0, 0, 16'h0, 16'h0003, 16'h0004, 4'd2, 0, 2'b00, 16'h0);
        tick();
        chk("add_lit", 32'(alu_result_q), 32'h0007);
        chk("add_valid", 32'(valid_q), 32'd1);

        // Forwarding from Exe/Mem and Mem/WB
        set_op(1, 4'd0, 0, 16'h0, 16'h0008, 16'h0008, 4'd1, 0, 2'b00, 16'h0);
        tick();
        set_op(1, 4'd1, 0, 16'h0, 16'hDEAD, 16'h0001, 4'd3, 0, 2'b01, 16'h0);
        tick();
        chk("fwd_exe_lit", 32'(alu_result_q), 32'h000F);
        set_op(1, 4'd1, 0, 16'h0, 16'hDEAD, 16'h0001, 4'd3, 0, 2'b10, 16'h0020);
        tick();
        chk("fwd_wb_lit", 32'(alu_result_q), 32'h001F);

        // Multiplies
        set_op(1, 4'd8, 0, 16'h0, 16'h0180, 16'h0200, 4'd4, 0, 2'b00, 16'h0);
        run_mulq("mul_1p5x2", 16'h0300, 1'b0);
        set_op(1, 4'd8, 0, 16'h0, 16'hFF00, 16'h0280, 4'd4, 0, 2'b00, 16'h0);
        run_mulq("mul_neg", 16'hFD80, 1'b0);
        set_op(1, 4'd8, 0, 16'h0, 16'h7F00, 16'h0200, 4'd4, 0, 2'b00, 16'h0);
        run_mulq("mul_satp", 16'h7FFF, 1'b1);
        set_op(1, 4'd8, 0, 16'h0, 16'h8000, 16'h0200, 4'd4, 1, 2'b00, 16'h0);
        run_mulq("mul_satn", 16'h8000, 1'b1);
        chk("mul_satn_store", 32'(mem_we_q), 32'd1);

        // Forwarded operand latched at acceptance
        set_op(1, 4'd0, 0, 16'h0, 16'h0180, 16'h0000, 4'd5, 0, 2'b00, 16'h0);
        tick();
        set_op(1, 4'd8, 0, 16'h0, 16'h1111, 16'h0200, 4'd6, 0, 2'b01, 16'h0);
        run_mulq("mul_fwd_exe", 16'h0300, 1'b0);
        set_op(1, 4'd8, 1, 16'h0200, 16'h2222, 16'h5555, 4'd6, 0, 2'b10,
               16'h0100);
        run_mulq("mul_fwd_wb", 16'h0200, 1'b0);

        // Reset while busy (BUSY count 5)
        set_op(1, 4'd8, 0, 16'h0, 16'h0180, 16'h0200, 4'd7, 0, 2'b00, 16'h0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("abort_res", 32'(alu_result_q), 32'h0);
        chk("abort_we", 32'(we_q), 32'h0);
        chk("abort_robj", 32'(robj_q), 32'h0);
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'h0);
        tick();
        set_op(1, 4'd0, 0, 16'h0, 16'h0001, 16'h0001, 4'd8, 0, 2'b00, 16'h0);
        tick();
        chk("post_abort_add", 32'(alu_result_q), 32'h0002);
        valid_in = 1'b0;
        tick();
        chk("post_abort_idle", 32'(stall), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (!exp_stall) begin
                valid_in  = ($urandom_range(0, 9) != 0);
                alu_op    = ($urandom_range(0, 5) == 0) ? 4'd8
                            : 4'($urandom_range(0, 15));
                use_imm   = 1'($urandom);
                robj_in   = 4'($urandom);
                we_in     = 1'($urandom);
                mem_we_in = 1'($urandom);
            end
            scramble();
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
